// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operand/result sequencer: op codes, flag bit
// positions and the sequencer state type.
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

    // Bit positions inside the 4-bit {c,z,n,o} flag vector
    localparam int FLG_C = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_N = 1;
    localparam int FLG_O = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_t;

endpackage : alu_pkg

// File: rtl/alu_op_sequencer.sv
// Initiator side of the ALU interface: registers ALU operands, waits one
// settle cycle, captures result/flags and returns them over valid/ready.
// Also keeps an accumulator, sticky carry/overflow and an op counter.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    input  logic             clr_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_s,
    input  logic [WIDTH-1:0] alu_y,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic [3:0]       rsp_flags,
    output logic [WIDTH-1:0] acc,
    output logic [1:0]       sticky_co,
    output logic [CNT_W-1:0] op_count
);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_s_q, alu_s_d;
    logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [1:0]       sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic rsp_done;

    // Handshake decode: ready only when idle, or when the pending response
    // is consumed this cycle; both forced low while reset is held.
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        if (rst_n) begin
            rsp_valid = (state_q == RESP);
            cmd_ready = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
        end
        accept   = cmd_valid && cmd_ready;
        rsp_done = rsp_valid && rsp_ready;
    end

    // Next-state and datapath update; every register holds by default.
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_s_d     = alu_s_q;
        rsp_y_d     = rsp_y_q;
        rsp_flags_d = rsp_flags_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        cnt_d       = cnt_q;

        if (clr_acc) begin
            acc_d    = '0;
            sticky_d = '0;
        end

        // Operand a from the accumulator sees a same-cycle clear as zero.
        if (accept) begin
            alu_a_d = cmd_use_acc ? (clr_acc ? '0 : acc_q) : cmd_a;
            alu_b_d = cmd_b;
            alu_s_d = cmd_op;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) state_d = EXEC;
            end
            EXEC: begin
                // Capture beats a concurrent clear for acc; sticky restarts
                // from this op's c/o when cleared.
                rsp_y_d     = alu_y;
                rsp_flags_d = alu_flags;
                acc_d       = alu_y;
                sticky_d    = (clr_acc ? 2'b00 : sticky_q)
                              | {alu_flags[FLG_C], alu_flags[FLG_O]};
                cnt_d       = cnt_q + 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_done) state_d = accept ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_s_q     <= '0;
            rsp_y_q     <= '0;
            rsp_flags_q <= '0;
            acc_q       <= '0;
            sticky_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_s_q     <= alu_s_d;
            rsp_y_q     <= rsp_y_d;
            rsp_flags_q <= rsp_flags_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s     = alu_s_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_flags = rsp_flags_q;
    assign acc       = acc_q;
    assign sticky_co = sticky_q;
    assign op_count  = cnt_q;

endmodule : alu_op_sequencer

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a 2-bit ALU model attached.
module tb_alu_op_sequencer;

    localparam int WIDTH = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_use_acc;
    logic             clr_acc;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_s;
    logic [WIDTH-1:0] alu_y;
    logic [3:0]       alu_flags;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic [3:0]       rsp_flags;
    logic [WIDTH-1:0] acc;
    logic [1:0]       sticky_co;
    logic [CNT_W-1:0] op_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .clr_acc(clr_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_y(alu_y), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_flags(rsp_flags),
        .acc(acc), .sticky_co(sticky_co), .op_count(op_count)
    );

    // Combinational 2-bit ALU: flags {c,z,n,o}; SUB carry = no borrow.
    always_comb begin
        logic [2:0] sum;
        logic       c;
        logic       o;
        sum = 3'd0;
        c   = 1'b0;
        o   = 1'b0;
        case (alu_s)
            2'b00: begin
                sum = {1'b0, alu_a} + {1'b0, alu_b};
                c   = sum[2];
                o   = (alu_a[1] == alu_b[1]) && (sum[1] != alu_a[1]);
            end
            2'b01: begin
                sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 3'd1;
                c   = sum[2];
                o   = (alu_a[1] != alu_b[1]) && (sum[1] != alu_a[1]);
            end
            2'b10:   sum = {1'b0, alu_a | alu_b};
            default: sum = {1'b0, alu_a & alu_b};
        endcase
        alu_y     = sum[1:0];
        alu_flags = {c, (sum[1:0] == 2'b00), sum[1], o};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command from IDLE, check latency and response, consume it.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [1:0] a,
                         input logic [1:0] b, input logic use_acc, input logic clr,
                         input logic check, input logic [1:0] exp_y, input logic [3:0] exp_f);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc; clr_acc = clr;
        cmd_valid = 1'b1;
        #1;
        if (check) chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0; clr_acc = 1'b0;
        if (check) chk({tag, ".rsp_valid_n1"}, 32'(rsp_valid), 32'd0);
        tick();
        if (check) begin
            chk({tag, ".rsp_valid_n2"}, 32'(rsp_valid), 32'd1);
            chk({tag, ".rsp_y"}, 32'(rsp_y), 32'(exp_y));
            chk({tag, ".rsp_flags"}, 32'(rsp_flags), 32'(exp_f));
            $display("[TB] %s op=%0d a=%0d b=%0d use_acc=%0d -> y=%0d flags=%b count=%0d",
                     tag, op, a, b, use_acc, rsp_y, rsp_flags, op_count);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        bit quiet;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = '0; cmd_b = '0;
        cmd_use_acc = 1'b0; clr_acc = 1'b0; rsp_ready = 1'b0;
        #1;
        chk("reset.cmd_ready_low", 32'(cmd_ready), 32'd0);
        tick(); tick();
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.op_count", 32'(op_count), 32'd0);
        chk("reset.acc", 32'(acc), 32'd0);
        chk("reset.alu_a", 32'(alu_a), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle.cmd_ready", 32'(cmd_ready), 32'd1);

        // Basic operations: 1+1=2 overflows signed; SUB carry means no borrow.
        do_op("add_1_1", 2'b00, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0011);
        chk("add.alu_s_hold", 32'(alu_s), 32'd0);
        do_op("sub_1_1", 2'b01, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1100);
        do_op("sub_0_1", 2'b01, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 2'd3, 4'b0010);
        chk("after3.op_count", 32'(op_count), 32'd3);
        chk("after3.alu_a_hold", 32'(alu_a), 32'd0);
        chk("after3.alu_b_hold", 32'(alu_b), 32'd1);

        // Backpressure: response held, then consumed in the same cycle a new op is taken.
        cmd_op = 2'b00; cmd_a = 2'd1; cmd_b = 2'd1; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
        tick();
        cmd_op = 2'b01; cmd_a = 2'd0; cmd_b = 2'd1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp.rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp.rsp_y", 32'(rsp_y), 32'd2);
            chk("bp.rsp_flags", 32'(rsp_flags), 32'b0011);
            chk("bp.cmd_ready", 32'(cmd_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp.cmd_ready_on_consume", 32'(cmd_ready), 32'd1);
        tick();
        rsp_ready = 1'b0; cmd_valid = 1'b0;
        chk("bp.next_exec_no_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("bp.next_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp.next_rsp_y", 32'(rsp_y), 32'd3);
        chk("bp.next_rsp_flags", 32'(rsp_flags), 32'b0010);
        $display("[TB] backpressure: back-to-back response y=%0d flags=%b", rsp_y, rsp_flags);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset asserted while the op is in EXEC drops it entirely.
        cmd_op = 2'b00; cmd_a = 2'd1; cmd_b = 2'd2; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("rst_exec.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_exec.cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_exec.rsp_y", 32'(rsp_y), 32'd0);
        chk("rst_exec.rsp_flags", 32'(rsp_flags), 32'd0);
        chk("rst_exec.acc", 32'(acc), 32'd0);
        chk("rst_exec.sticky", 32'(sticky_co), 32'd0);
        chk("rst_exec.op_count", 32'(op_count), 32'd0);
        chk("rst_exec.alu_abs", 32'({alu_a, alu_b, alu_s}), 32'd0);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid !== 1'b0) quiet = 1'b0;
        end
        chk("rst_exec.no_rsp_after", 32'(quiet), 32'd1);
        $display("[TB] reset during EXEC: outputs cleared, no response");

        // Accumulator chain; clear on the first accept makes operand a = 0.
        do_op("acc1", 2'b00, 2'd3, 2'd1, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0000);
        do_op("acc2", 2'b00, 2'd3, 2'd1, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0011);
        do_op("acc3", 2'b00, 2'd3, 2'd1, 1'b1, 1'b0, 1'b1, 2'd3, 4'b0010);
        do_op("acc4", 2'b00, 2'd3, 2'd1, 1'b1, 1'b0, 1'b1, 2'd0, 4'b1100);
        chk("chain.acc", 32'(acc), 32'd0);
        // c from 3+1 and o from 1+1 both accumulate.
        chk("chain.sticky_co", 32'(sticky_co), 32'b11);
        chk("chain.op_count", 32'(op_count), 32'd4);
        clr_acc = 1'b1;
        tick();
        clr_acc = 1'b0;
        chk("clr.sticky_co", 32'(sticky_co), 32'd0);
        $display("[TB] clr_acc alone: acc=%0d sticky=%b", acc, sticky_co);

        // Counter wrap: run up to 255, then one more AND op wraps to 0.
        for (int i = 0; i < 251; i++)
            do_op("fill", 2'b11, 2'd3, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        chk("wrap.op_count_255", 32'(op_count), 32'd255);
        do_op("and_3_2", 2'b11, 2'd3, 2'd2, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0010);
        chk("wrap.op_count_0", 32'(op_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_alu_op_sequencer
